// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
//  Module   : lsu
//  Purpose  : Multi-cycle RV32I load/store unit. Accepts one request at a time
//             from EXECUTE, drives a word-wide synchronous data RAM with byte
//             enables and returns an extended load value, a store acknowledge
//             or an error flag to WRITE_BACK.
//  Ports    : clk, rst (sync, active-low)
//             req_*  : request handshake from EXECUTE (valid/ready, we,
//                      funct3, byte address, store data)
//             resp_* : one-cycle response pulse (rdata, err)
//             mem_*  : data RAM strobe, byte-lane write enables, word address,
//                      lane-replicated write data, read data
//  Revision : 1.0 - initial release
// ============================================================================
module lsu #(
   parameter int ADDR_W  = 7,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        addr_q, addr_d;
   logic              err_q, err_d;
   logic [31:0]       ld_q, ld_d;

   logic              mem_en_q, mem_en_d;
   logic [3:0]        mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              resp_valid_q, resp_valid_d;
   logic [31:0]       resp_rdata_q, resp_rdata_d;
   logic              resp_err_q, resp_err_d;

   logic              w_accept;
   logic              w_illegal;
   logic [31:0]       w_shift;
   logic [31:0]       w_ld_ext;

   // Address bits above the RAM window are ignored, so accesses wrap.
   logic              w_unused_addr_hi;
   assign w_unused_addr_hi = ^req_addr[31:ADDR_W+2];

   assign req_ready = (state_q == S_IDLE) && rst;
   assign w_accept  = req_valid && req_ready;

   // Request legality: unsupported funct3 or an address not aligned to size.
   always_comb begin
      w_illegal = 1'b0;
      if (req_we) begin
         case (req_funct3)
            3'd0:    w_illegal = 1'b0;
            3'd1:    w_illegal = req_addr[0];
            3'd2:    w_illegal = |req_addr[1:0];
            default: w_illegal = 1'b1;
         endcase
      end else begin
         case (req_funct3)
            3'd0, 3'd4: w_illegal = 1'b0;
            3'd1, 3'd5: w_illegal = req_addr[0];
            3'd2:       w_illegal = |req_addr[1:0];
            default:    w_illegal = 1'b1;
         endcase
      end
   end

   // Align the addressed byte/half to bit 0, then extend per funct3.
   assign w_shift = mem_rdata >> {addr_q, 3'b000};

   always_comb begin
      case (f3_q)
         3'd0:    w_ld_ext = {{24{w_shift[7]}}, w_shift[7:0]};
         3'd1:    w_ld_ext = {{16{w_shift[15]}}, w_shift[15:0]};
         3'd4:    w_ld_ext = {24'd0, w_shift[7:0]};
         3'd5:    w_ld_ext = {16'd0, w_shift[15:0]};
         default: w_ld_ext = w_shift;
      endcase
   end

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (w_accept) state_d = w_illegal ? S_RESP : S_ACCESS;
         S_ACCESS: state_d = we_q ? S_RESP : S_WAIT;
         S_WAIT:   if (cnt_q == 3'd1) state_d = S_RESP;
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   // RAM controls are registered on the accepting edge so mem_en is high for
   // exactly the ACCESS cycle. Response outputs are registered from the RESP
   // state, so the pulse appears on the edge leaving RESP.
   always_comb begin
      we_d        = we_q;
      f3_d        = f3_q;
      addr_d      = addr_q;
      err_d       = err_q;
      ld_d        = ld_q;
      cnt_d       = cnt_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 4'b0000;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      if (w_accept) begin
         we_d   = req_we;
         f3_d   = req_funct3;
         addr_d = req_addr[1:0];
         err_d  = w_illegal;
         ld_d   = 32'd0;
         if (!w_illegal) begin
            mem_en_d   = 1'b1;
            mem_addr_d = req_addr[ADDR_W+1:2];
            if (req_we) begin
               case (req_funct3[1:0])
                  2'd0: begin
                     mem_we_d    = 4'b0001 << req_addr[1:0];
                     mem_wdata_d = {4{req_wdata[7:0]}};
                  end
                  2'd1: begin
                     mem_we_d    = req_addr[1] ? 4'b1100 : 4'b0011;
                     mem_wdata_d = {2{req_wdata[15:0]}};
                  end
                  default: begin
                     mem_we_d    = 4'b1111;
                     mem_wdata_d = req_wdata;
                  end
               endcase
            end
         end
      end

      if ((state_q == S_ACCESS) && !we_q) begin
         cnt_d = 3'(MEM_LAT);
      end else if (state_q == S_WAIT) begin
         cnt_d = cnt_q - 3'd1;
         if (cnt_q == 3'd1) ld_d = w_ld_ext;
      end

      resp_valid_d = (state_q == S_RESP);
      resp_err_d   = (state_q == S_RESP) && err_q;
      resp_rdata_d = ((state_q == S_RESP) && !err_q && !we_q) ? ld_q : 32'd0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q        <= 3'd0;
         we_q         <= 1'b0;
         f3_q         <= 3'd0;
         addr_q       <= 2'd0;
         err_q        <= 1'b0;
         ld_q         <= 32'd0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 4'b0000;
         mem_addr_q   <= '0;
         mem_wdata_q  <= 32'd0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         resp_err_q   <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         f3_q         <= f3_d;
         addr_q       <= addr_d;
         err_q        <= err_d;
         ld_q         <= ld_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign mem_en     = mem_en_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu
//  Purpose  : Self-checking bench for lsu. Two instances (MEM_LAT 1 and 3)
//             each drive a behavioural RAM; a byte-level reference memory
//             predicts responses and RAM traffic, a negedge monitor compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;

   localparam int LATS [2] = '{1, 3};

   typedef struct {
      int          k;
      int          cyc;
      logic [31:0] d;
      logic        e;
   } resp_t;

   typedef struct {
      int          k;
      int          cyc;
      logic [6:0]  a;
      logic [3:0]  we;
      logic [31:0] wd;
   } mem_t;

   logic        clk = 1'b0;
   logic        rst        [2];
   logic        req_valid  [2];
   logic        req_ready  [2];
   logic        req_we     [2];
   logic [2:0]  req_funct3 [2];
   logic [31:0] req_addr   [2];
   logic [31:0] req_wdata  [2];
   logic        resp_valid [2];
   logic [31:0] resp_rdata [2];
   logic        resp_err   [2];
   logic        mem_en     [2];
   logic [3:0]  mem_we     [2];
   logic [6:0]  mem_addr   [2];
   logic [31:0] mem_wdata  [2];
   logic [31:0] mem_rdata  [2];

   logic [31:0] ram     [2][128];
   logic [31:0] ref_mem [2][128];
   logic [31:0] pipe    [2][3];

   resp_t rq[$];
   mem_t  mq[$];

   int cyc         = 0;
   int vectors     = 0;
   int n_cmp       = 0;
   int miscompares = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   generate
      for (genvar g = 0; g < 2; g++) begin : g_dut
         lsu #(.ADDR_W(7), .MEM_LAT(LATS[g])) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_we     (req_we[g]),
            .req_funct3 (req_funct3[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .resp_valid (resp_valid[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g]),
            .mem_en     (mem_en[g]),
            .mem_we     (mem_we[g]),
            .mem_addr   (mem_addr[g]),
            .mem_wdata  (mem_wdata[g]),
            .mem_rdata  (mem_rdata[g])
         );
      end
   endgenerate

   // Synchronous RAM: read data appears LAT edges after the sampling edge;
   // a poison value fills the pipe whenever no access is made.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (mem_en[k]) begin
            for (int i = 0; i < 4; i++) begin
               if (mem_we[k][i]) ram[k][mem_addr[k]][8*i +: 8] <= mem_wdata[k][8*i +: 8];
            end
         end
         pipe[k][0] <= mem_en[k] ? ram[k][mem_addr[k]] : 32'hDEAD_BEEF;
         pipe[k][1] <= pipe[k][0];
         pipe[k][2] <= pipe[k][1];
      end
   end

   always_comb begin
      for (int k = 0; k < 2; k++) mem_rdata[k] = pipe[k][LATS[k]-1];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic flag(input string nm, input int k);
      n_cmp++;
      miscompares++;
      $display("FAIL %s: inst %0d (t=%0t)", nm, k, $time);
   endtask

   // ------------------------------------------------------------------ monitor
   always @(negedge clk) begin
      resp_t r;
      mem_t  m;
      for (int k = 0; k < 2; k++) begin
         if (resp_valid[k]) begin
            if (rq.size() == 0) flag("resp_unexpected", k);
            else begin
               r = rq.pop_front();
               chk("resp_inst",  k, r.k);
               chk("resp_cycle", cyc, r.cyc);
               chk("resp_rdata", resp_rdata[k], r.d);
               chk("resp_err",   {31'd0, resp_err[k]}, {31'd0, r.e});
            end
         end
         if (mem_en[k]) begin
            if (mq.size() == 0) flag("mem_en_unexpected", k);
            else begin
               m = mq.pop_front();
               chk("mem_inst",  k, m.k);
               chk("mem_cycle", cyc, m.cyc);
               chk("mem_addr",  {25'd0, mem_addr[k]}, {25'd0, m.a});
               chk("mem_we",    {28'd0, mem_we[k]}, {28'd0, m.we});
               if (m.we != 4'b0000) chk("mem_wdata", mem_wdata[k], m.wd);
            end
         end else if (mem_we[k] != 4'b0000) begin
            flag("mem_we_without_en", k);
         end
      end
   end

   // ------------------------------------------------------------------ driver
   // Called at a negedge; returns at the negedge after acceptance.
   task automatic issue(input int k, input bit we, input bit [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input bit hold);
      resp_t       r;
      mem_t        m;
      bit          err;
      int          nb, w, lane, t, acc;
      logic [31:0] word, sh;

      w  = int'(addr[8:2]);
      nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      if (we) err = (f3 > 3'd2) || ((int'(addr[1:0]) % nb) != 0);
      else    err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || ((int'(addr[1:0]) % nb) != 0);

      r.k = k; r.e = err; r.d = 32'd0;
      m.k = k; m.a = addr[8:2]; m.we = 4'b0000; m.wd = 32'd0;

      if (!err && !we) begin
         word = ref_mem[k][w];
         sh   = word >> (8 * int'(addr[1:0]));
         case (f3)
            3'd0:    r.d = (sh[7]  ? 32'hFFFF_FF00 : 32'd0) | (sh & 32'h0000_00FF);
            3'd1:    r.d = (sh[15] ? 32'hFFFF_0000 : 32'd0) | (sh & 32'h0000_FFFF);
            3'd4:    r.d = sh & 32'h0000_00FF;
            3'd5:    r.d = sh & 32'h0000_FFFF;
            default: r.d = word;
         endcase
      end
      if (!err && we) begin
         for (int b = 0; b < nb; b++) begin
            lane = int'(addr[1:0]) + b;
            ref_mem[k][w][8*lane +: 8] = wd[8*b +: 8];
            m.we = m.we | 4'(1 << lane);
         end
         case (nb)
            1:       m.wd = {4{wd[7:0]}};
            2:       m.wd = {2{wd[15:0]}};
            default: m.wd = wd;
         endcase
      end

      req_valid[k]  = 1'b1;
      req_we[k]     = we;
      req_funct3[k] = f3;
      req_addr[k]   = addr;
      req_wdata[k]  = wd;
      t = 0;
      while (!req_ready[k]) begin
         @(negedge clk);
         t++;
         if (t > 50) begin
            flag("ready_timeout", k);
            req_valid[k] = 1'b0;
            return;
         end
      end
      acc   = cyc + 1;
      r.cyc = acc + (err ? 1 : (we ? 2 : LATS[k] + 2));
      m.cyc = acc;
      rq.push_back(r);
      if (!err) mq.push_back(m);
      vectors++;
      @(negedge clk);
      if (!hold) req_valid[k] = 1'b0;
   endtask

   task automatic wait_drain(input int k);
      int t;
      t = 0;
      while ((rq.size() != 0) || (mq.size() != 0)) begin
         @(negedge clk);
         t++;
         if (t > 60) begin
            flag("drain_timeout", k);
            rq.delete();
            mq.delete();
         end
      end
   endtask

   task automatic chk_quiet(input int k);
      chk("rst_resp_valid", {31'd0, resp_valid[k]}, 32'd0);
      chk("rst_resp_err",   {31'd0, resp_err[k]},   32'd0);
      chk("rst_resp_rdata", resp_rdata[k],          32'd0);
      chk("rst_mem_en",     {31'd0, mem_en[k]},     32'd0);
      chk("rst_mem_we",     {28'd0, mem_we[k]},     32'd0);
      chk("rst_req_ready",  {31'd0, req_ready[k]},  32'd0);
   endtask

   task automatic run_inst(input int k);
      bit          we, hold;
      bit [2:0]    f3;
      logic [31:0] addr;
      int          pick;

      // Directed accesses to word 5 = 0x80FF7F01 and word 8.
      issue(k, 1'b0, 3'd2, 32'h14, 32'd0, 1'b0);
      issue(k, 1'b0, 3'd0, 32'h17, 32'd0, 1'b0);
      issue(k, 1'b0, 3'd4, 32'h17, 32'd0, 1'b0);
      issue(k, 1'b0, 3'd1, 32'h16, 32'd0, 1'b0);
      issue(k, 1'b0, 3'd5, 32'h14, 32'd0, 1'b0);
      issue(k, 1'b1, 3'd0, 32'h21, 32'h1234_56AB, 1'b0);
      issue(k, 1'b0, 3'd2, 32'h20, 32'd0, 1'b0);
      issue(k, 1'b0, 3'd2, 32'h15, 32'd0, 1'b0);
      issue(k, 1'b1, 3'd1, 32'h23, $urandom(), 1'b0);
      issue(k, 1'b0, 3'd3, 32'h14, 32'd0, 1'b0);
      issue(k, 1'b0, 3'd2, 32'h20, 32'd0, 1'b0);
      issue(k, 1'b0, 3'd2, 32'h14, 32'd0, 1'b0);
      wait_drain(k);

      // Abandon a load while it waits on the RAM.
      issue(k, 1'b0, 3'd2, 32'h14, 32'd0, 1'b0);
      @(negedge clk);
      rst[k] = 1'b0;
      if (rq.size() != 0) rq.delete(rq.size() - 1);
      @(negedge clk);
      chk_quiet(k);
      @(negedge clk);
      rst[k] = 1'b1;
      #1;
      chk("ready_after_reset", {31'd0, req_ready[k]}, 32'd1);
      repeat (8) @(negedge clk);
      issue(k, 1'b0, 3'd2, 32'h14, 32'd0, 1'b0);
      wait_drain(k);

      // Random traffic, mostly legal, often with req_valid held high.
      for (int n = 0; n < 200; n++) begin
         we = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
         else begin
            pick = $urandom_range(0, 4);
            if (we) f3 = 3'(pick % 3);
            else case (pick)
               0: f3 = 3'd0;
               1: f3 = 3'd1;
               2: f3 = 3'd2;
               3: f3 = 3'd4;
               default: f3 = 3'd5;
            endcase
         end
         addr = ($urandom() & 32'hFFFF_FE00) | (32'($urandom_range(0, 15)) << 2)
              | 32'($urandom_range(0, 3));
         hold = ($urandom_range(0, 3) != 0);
         issue(k, we, f3, addr, $urandom(), hold);
         if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      req_valid[k] = 1'b0;
      wait_drain(k);
   endtask

   initial begin
      logic [31:0] v;
      for (int k = 0; k < 2; k++) begin
         rst[k]        = 1'b0;
         req_valid[k]  = 1'b0;
         req_we[k]     = 1'b0;
         req_funct3[k] = 3'd0;
         req_addr[k]   = 32'd0;
         req_wdata[k]  = 32'd0;
         for (int w = 0; w < 128; w++) begin
            v = (w == 5) ? 32'h80FF_7F01 : $urandom();
            ram[k][w]     = v;
            ref_mem[k][w] = v;
         end
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk_quiet(k);
         chk("rst_mem_addr",  {25'd0, mem_addr[k]}, 32'd0);
         chk("rst_mem_wdata", mem_wdata[k],         32'd0);
      end
      rst[0] = 1'b1;
      rst[1] = 1'b1;
      #1;
      chk("ready_after_init0", {31'd0, req_ready[0]}, 32'd1);
      chk("ready_after_init1", {31'd0, req_ready[1]}, 32'd1);

      run_inst(0);
      run_inst(1);

      repeat (5) @(negedge clk);
      chk("resp_queue_empty", rq.size(), 32'd0);
      chk("mem_queue_empty",  mq.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/lsu.md
Name: lsu

Overview:
- Multi-cycle load/store unit for the RV32I core; sits directly downstream of the EXECUTE stage.
- Consumes the effective address (ALU result), funct3, store data and the load/store flag; drives a word-wide synchronous data RAM with byte enables.
- Returns a sign- or zero-extended load value, or a store acknowledge, to WRITE_BACK.
- Flags misaligned or unsupported accesses instead of touching memory.

Parameters:
ADDR_W, 7, data RAM word-address width (128 words, same depth as the instruction ROM).
MEM_LAT, 1, RAM read latency in cycles, counted from the edge that samples mem_en to valid mem_rdata; legal range 1..7.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active-low: unit held in reset while rst==0.
req_valid  in  1  EXECUTE presents a memory request.
req_ready  out  1  unit can accept a request; equals (state==IDLE) && rst.
req_we  in  1  1=store, 0=load.
req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
req_addr  in  32  byte effective address.
req_wdata  in  32  store data (rs2 value).
resp_valid  out  1  one-cycle pulse: response available.
resp_rdata  out  32  extended load data; 0 for stores and errors.
resp_err  out  1  qualifies resp_valid: misaligned address or illegal funct3.
mem_en  out  1  RAM access strobe.
mem_we  out  4  byte-lane write enables; lane i = bits [8i+7:8i].
mem_addr  out  ADDR_W  word address = addr[ADDR_W+1:2]; upper address bits ignored, so addresses wrap.
mem_wdata  out  32  lane-replicated store data.
mem_rdata  in  32  RAM read data.

Behaviour:
- Reset (rst==0 at an edge): state=IDLE, wait counter=0, captured request cleared. resp_valid, resp_err, mem_en=0; mem_we=0; mem_addr, mem_wdata, resp_rdata=0.
- Reset mid-operation: the transaction is abandoned and no response is produced. req_ready=1 on the first cycle after rst returns high.
- States: IDLE, ACCESS, WAIT, RESP. All outputs except req_ready are registered.
- IDLE: on req_valid && req_ready, capture we, funct3, addr, wdata. Next state is RESP with err=1 if the request is illegal, otherwise ACCESS. Request inputs need not be held after acceptance.
- Illegal requests:
  - loads: funct3 3, 6 or 7; LH/LHU with addr[0]!=0; LW with addr[1:0]!=0.
  - stores: funct3>=3; SH with addr[0]!=0; SW with addr[1:0]!=0.
- ACCESS (exactly 1 cycle):
  - mem_en=1 and mem_addr driven; all other cycles mem_en=0, mem_we=0.
  - Store: mem_we SB = 1<<addr[1:0]; SH = 4'b0011 (addr[1]=0) or 4'b1100 (addr[1]=1); SW = 4'b1111. mem_wdata SB = byte replicated x4; SH = half replicated x2; SW = word. Next state RESP.
  - Load: mem_we=0. Next state WAIT; counter loads MEM_LAT.
- WAIT: counter decrements each cycle. When the counter reaches 1, mem_rdata is sampled on that edge: shift right by 8*addr[1:0], then extend per funct3 (LB/LH sign, LBU/LHU zero, LW none). Next state RESP.
- RESP (exactly 1 cycle): resp_valid=1 with resp_rdata and resp_err. Next state IDLE.
- Latency, counted in edges after the accepting edge until resp_valid goes high: load = MEM_LAT+2; store = 2; error = 1.
- Throughput: one request in flight. req_ready=0 from the accepting edge until back in IDLE; req_valid is ignored while not ready.
- No write to RAM on any error; mem_en never asserted for an error.

Test Plan:
- RAM word 5 = 0x80FF7F01; LW addr 0x14, MEM_LAT=1 -> single mem_en with mem_addr=5, mem_we=0; resp_valid 3 edges after accept, rdata=0x80FF7F01, err=0.
- Same word: LB 0x17 -> 0xFFFFFF80; LBU 0x17 -> 0x00000080; LH 0x16 -> 0xFFFF80FF; LHU 0x14 -> 0x00007F01.
- SB addr 0x21, wdata 0x123456AB -> mem_addr=8, mem_we=4'b0010, mem_wdata=0xABABABAB; resp_valid 2 edges after accept, rdata=0. Read back word 8: only byte 1 changed.
- LW 0x15; SH 0x23; load funct3=3 -> mem_en never asserted, resp_valid+resp_err 1 edge after accept, rdata=0, RAM unchanged.
- Drive rst=0 during WAIT -> no resp_valid; mem_en=0; req_ready=1 on the first cycle after rst=1; a subsequent LW completes normally.
- MEM_LAT=3: LW 0x14 -> resp_valid 5 edges after accept with 0x80FF7F01. Hold req_valid high continuously -> next accept only when req_ready returns, no request lost or duplicated.
